// File: rtl/dfmul_pkg.sv
// rtl/dfmul_pkg.sv - shared constants, state encodings and binary64 helpers for the DFMUL harness
package dfmul_pkg;

    localparam int DFMUL_NUM_VECTORS = 20;

    localparam int          F64_EXP_W   = 11;
    localparam int          F64_MAN_W   = 52;
    localparam logic [10:0] F64_EXP_MAX = 11'h7FF;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_WAIT = 4'b0010,
        ST_CMP  = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    // Exponent all ones with a non-zero mantissa; infinities are not NaNs.
    function automatic logic f64_is_nan(input logic [63:0] x);
        return (x[F64_MAN_W +: F64_EXP_W] == F64_EXP_MAX) && (x[F64_MAN_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/dfmul_f64_cmp.sv
// rtl/dfmul_f64_cmp.sv - binary64 inequality; DFMUL_CHK_NAN_EQ_EN makes any two NaNs compare equal
module dfmul_f64_cmp
    import dfmul_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        neq
);

`ifdef DFMUL_CHK_NAN_EQ_EN
    logic both_nan;

    assign both_nan = f64_is_nan(a) & f64_is_nan(b);
    assign neq      = (a != b) & ~both_nan;
`else
    assign neq = (a != b);
`endif

endmodule

// File: rtl/dfmul_result_checker.sv
// rtl/dfmul_result_checker.sv - compares multiplier products against a golden ROM and counts mismatches (option: DFMUL_CHK_NAN_EQ_EN)
module dfmul_result_checker
    import dfmul_pkg::*;
#(
    parameter int NUM_VECTORS = DFMUL_NUM_VECTORS,
    parameter int IDX_W       = 5,
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 5
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  gold_address0,
    output logic              gold_ce0,
    input  logic [DATA_W-1:0] gold_q0,
    output logic [31:0]       ap_return
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   res_reg;
    logic                accept;
    logic                miss;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cnt     <= '0;
            res_reg <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && ap_start) begin
                idx <= '0;
                cnt <= '0;
            end
            if (accept) begin
                res_reg <= res_data;
            end
            // The golden word read on the accept cycle arrives exactly now.
            if (state == ST_CMP) begin
                if (miss && cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                if (idx != IDX_LAST) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        res_ready = 1'b0;
        ap_done   = 1'b0;
        unique case (state)
            ST_IDLE: if (ap_start) state_nxt = ST_WAIT;
            ST_WAIT: begin
                res_ready = 1'b1;
                if (res_valid) state_nxt = ST_CMP;
            end
            ST_CMP:  state_nxt = (idx == IDX_LAST) ? ST_DONE : ST_WAIT;
            ST_DONE: begin
                ap_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept        = res_ready & res_valid;
    assign gold_ce0      = accept;
    assign gold_address0 = idx;
    assign ap_ready      = ap_done;
    assign ap_idle       = (state == ST_IDLE) & ~ap_start;
    assign ap_return     = 32'(cnt);

    dfmul_f64_cmp u_cmp (
        .a   (res_reg),
        .b   (gold_q0),
        .neq (miss)
    );

endmodule
